// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C write arbiter slice.
package i2c_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 40000;
  localparam int TO_W_DEF    = 16;
  localparam int DEV_W       = 7;
  localparam int REG_W       = 8;
  localparam int DATA_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/i2c_write_arbiter_if.sv
// Requester and I2C-master signals of the write arbiter; slave = arbiter side.
interface i2c_write_arbiter_if
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) ();
  logic [NUM_REQ-1:0]        req;
  logic [DEV_W*NUM_REQ-1:0]  req_dev_addr;
  logic [REG_W*NUM_REQ-1:0]  req_reg_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic                      m_en;
  logic [DEV_W-1:0]          m_dev_addr;
  logic [REG_W-1:0]          m_data_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_done;

  modport slave (
    input  req, req_dev_addr, req_reg_addr, req_wdata, m_done,
    output gnt, done, err, m_en, m_dev_addr, m_data_addr, m_wdata
  );

  modport master (
    output req, req_dev_addr, req_reg_addr, req_wdata, m_done,
    input  gnt, done, err, m_en, m_dev_addr, m_data_addr, m_wdata
  );
endinterface

// File: rtl/i2c_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);
  always_comb begin
    winner = '0;
    idx    = '0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        winner = '0;
        winner[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ register-write requesters.
// state | meaning: IDLE wait for req | GRANT fields latched | BUSY master running | GAP 2-cycle cool-down
module i2c_write_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int TO_W           = TO_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  i2c_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] win_q, win_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               gap_q, gap_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DEV_W-1:0]   dev_q, dev_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dev_d   = dev_q;
    reg_d   = reg_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          // Capture fields with the winner so they are already valid during GRANT.
          state_d = ST_GRANT;
          win_d   = pick_oh;
          ptr_d   = IW'(next_ptr(int'(pick_idx), NUM_REQ));
          dev_d   = bus.req_dev_addr[int'(pick_idx)*DEV_W +: DEV_W];
          reg_d   = bus.req_reg_addr[int'(pick_idx)*REG_W +: REG_W];
          data_d  = bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      ST_GRANT: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.m_done) begin
          done_d  = 1'b1;
          gap_d   = 1'b0;
          state_d = ST_GAP;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          gap_d   = 1'b0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q) state_d = ST_IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt         = (state_q == ST_GRANT || state_q == ST_BUSY) ? win_q : '0;
  assign bus.done        = done_q ? win_q : '0;
  assign bus.err         = err_q;
  assign bus.m_en        = (state_q == ST_BUSY);
  assign bus.m_dev_addr  = dev_q;
  assign bus.m_data_addr = reg_q;
  assign bus.m_wdata     = data_q;
endmodule

// File: doc/i2c_write_arbiter.md
I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 40000, max clk cycles in BUSY before abort.
REQ-003 SHALL have parameter TO_W, default 16, timeout counter width.
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request; level, held until its done pulse.
REQ-007 SHALL have port req_dev_addr  input  7*NUM_REQ  packed 7-bit slave address; slice i belongs to requester i.
REQ-008 SHALL have port req_reg_addr  input  8*NUM_REQ  packed register address per requester.
REQ-009 SHALL have port req_wdata  input  8*NUM_REQ  packed write byte per requester.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant; all zero when no transaction is granted.
REQ-011 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err  output  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-013 SHALL have port m_en  output  1  enable to the I2C master.
REQ-014 SHALL have ports m_dev_addr  output  7, m_data_addr  output  8, m_wdata  output  8: latched transaction fields to the master.
REQ-015 SHALL have port m_done  input  1  master done flag.

Function
REQ-016 SHALL implement states IDLE, GRANT, BUSY, GAP.
REQ-017 IDLE: if any req bit is set, SHALL select the winner round-robin and go to GRANT next cycle; otherwise stay.
REQ-018 Round-robin: priority pointer starts at requester 0; after serving requester i, requester (i+1) mod NUM_REQ SHALL get highest priority.
REQ-019 GRANT (1 cycle): SHALL latch the winner's dev/reg/data slices into m_* registers, assert gnt[winner], and clear the timeout counter.
REQ-020 BUSY: m_en SHALL be 1 and gnt held; timeout counter SHALL increment every cycle.
REQ-021 BUSY exit on m_done=1: m_en SHALL drop and done[winner] SHALL pulse on the next cycle; the state then moves to GAP.
REQ-022 BUSY exit on counter reaching TIMEOUT_CYCLES-1 with m_done=0: SHALL behave as REQ-021 and additionally pulse err.
REQ-023 If m_done and timeout coincide, completion SHALL take precedence and err SHALL stay 0.
REQ-024 GAP: m_en=0 and gnt=0 for exactly 2 cycles, so the master returns to idle; then the state SHALL return to IDLE.
REQ-025 m_dev_addr, m_data_addr and m_wdata SHALL remain stable from GRANT through GAP; requester input changes after GRANT SHALL be ignored.
REQ-026 Deassertion of req[winner] mid-transaction SHALL NOT abort; the transaction completes and done still pulses.
REQ-027 A requester holding req after its done pulse SHALL be treated as a new request, arbitrated by round-robin.
REQ-028 Minimum request-to-m_en latency SHALL be 2 cycles (IDLE→GRANT→BUSY).

Reset
REQ-029 On rst_n low: state=IDLE, pointer=0, gnt=0, done=0, err=0, m_en=0, m_* fields=0, counter=0, asynchronously.
REQ-030 Reset mid-BUSY SHALL drop m_en immediately and SHALL NOT generate done or err.

Structure
REQ-031 State encoding, NUM_REQ/TIMEOUT defaults and packed-field widths SHALL reside in shared package i2c_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick (inputs req, pointer; output one-hot winner and index), combinational.

Verification
REQ-033 Single req[2]=1 with dev 0x50, reg 0x10, data 0xA5 -> m_en high 2 cycles later with those fields; m_done pulse -> done[2] next cycle, err=0.
REQ-034 req=4'b1111 held, each m_done after 100 cycles -> grants in order 0,1,2,3,0, with 2-cycle GAP each.
REQ-035 m_done never asserted, TIMEOUT_CYCLES=50 -> m_en drops after 50 BUSY cycles; done and err pulse together.
REQ-036 m_done asserted on the final timeout cycle -> done pulses, err stays 0.
REQ-037 req_wdata changed and req[1] dropped during BUSY -> m_wdata unchanged; done[1] still pulses.
REQ-038 rst_n low mid-BUSY -> m_en, gnt, done, err all 0 immediately; after release, pointer restarts at 0.
